controlador_barramento: RTL

- Shared-bus and memory side of the snoopy MSI protocol.
- Collects each processor's 11-bit bus output and arbitrates requests round-robin.
- Broadcasts the granted request on the common bus input, gathers snoop "return" responses, and supplies data from main memory when no cache answers.
- Absorbs writebacks into a small backing memory.
- Sits between NPROC cache/processor controllers as the single source of their bus input.

---
 rtl/controlador_barramento.sv | 133 +++++++++++++
 1 files changed

// File: rtl/controlador_barramento.sv
// controlador_barramento: round-robin MSI bus arbiter with snoop collection and writeback memory
module controlador_barramento #(
  parameter int NPROC      = 4,
  parameter int SNOOP_WAIT = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [11*NPROC-1:0] barout_all,
  output logic [10:0]         barin,
  output logic                busy,
  output logic                overflow,
  output logic [5:0]          mem_dbg
);
  typedef enum logic [1:0] {IDLE, BCAST, SNOOP, RESP} state_t;
  state_t state, state_n;
  logic [NPROC-1:0] pend, pend_n;
  logic [10:0] req [NPROC];
  logic [10:0] req_n [NPROC];
  logic [10:0] slice [NPROC];
  logic [2:0] mem [2];
  logic [2:0] mem_n [2];
  logic [1:0] last_grant, last_grant_n, cur, cur_n, grant_k;
  logic [2:0] timer, timer_n, hit_data;
  logic [10:0] barin_n;
  logic overflow_n, grant_ok, hit, hit_tag;
  int best, d;
  for (genvar g = 0; g < NPROC; g++) assign slice[g] = barout_all[11*g +: 11];
  assign busy = (state != IDLE) | (|pend);
  assign mem_dbg = {mem[1], mem[0]};
  // round-robin pick: pending index with the smallest cyclic distance after last_grant
  always_comb begin
    grant_ok = 1'b0;
    grant_k = '0;
    best = NPROC;
    d = 0;
    for (int j = 0; j < NPROC; j++) begin
      d = (j + NPROC - int'(last_grant) - 1) % NPROC;
      if (pend[j] && d < best) begin
        grant_ok = 1'b1;
        grant_k = 2'(j);
        best = d;
      end
    end
  end
  // snoop return aimed at the current requester; descending scan lets the lowest index win
  always_comb begin
    hit = 1'b0;
    hit_tag = 1'b0;
    hit_data = '0;
    for (int j = NPROC - 1; j >= 0; j--)
      if (2'(j) != cur && slice[j][5:4] == 2'b11 && slice[j][9:8] == cur) begin
        hit = 1'b1;
        hit_tag = slice[j][3];
        hit_data = slice[j][2:0];
      end
  end
  // request capture, writeback absorption and transaction sequencing
  always_comb begin
    state_n = state;
    pend_n = pend;
    req_n = req;
    mem_n = mem;
    last_grant_n = last_grant;
    cur_n = cur;
    timer_n = timer;
    overflow_n = overflow;
    barin_n = '0;
    for (int j = 0; j < NPROC; j++) begin
      if (slice[j][5:4] == 2'b01 || slice[j][5:4] == 2'b10) begin
        if (pend[j]) overflow_n = 1'b1;
        else begin
          req_n[j] = slice[j];
          pend_n[j] = 1'b1;
        end
      end
      if (slice[j][5:4] != 2'b00 && slice[j][7]) mem_n[slice[j][6]] = slice[j][2:0];
    end
    case (state)
      IDLE: if (grant_ok) begin
        cur_n = grant_k;
        barin_n = {1'b0, grant_k, 2'b00, req[grant_k][5:4], req[grant_k][3], 3'b000};
        state_n = BCAST;
      end
      BCAST: if (req[cur][5:4] == 2'b10) begin
        pend_n[cur] = 1'b0;
        last_grant_n = cur;
        state_n = IDLE;
      end else begin
        timer_n = '0;
        state_n = SNOOP;
      end
      SNOOP: if (hit) begin
        barin_n = {1'b1, cur, 2'b00, 2'b11, hit_tag, hit_data};
        state_n = RESP;
      end else begin
        timer_n = timer + 3'd1;
        if (timer + 3'd1 == 3'(SNOOP_WAIT)) begin
          barin_n = {1'b0, cur, 2'b00, 2'b11, req[cur][3], mem_n[req[cur][3]]};
          state_n = RESP;
        end
      end
      default: begin
        pend_n[cur] = 1'b0;
        last_grant_n = cur;
        state_n = IDLE;
      end
    endcase
  end
  // state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pend <= '0;
      req <= '{default: '0};
      mem <= '{default: '0};
      last_grant <= 2'(NPROC - 1);
      cur <= '0;
      timer <= '0;
      overflow <= 1'b0;
      barin <= '0;
    end else begin
      state <= state_n;
      pend <= pend_n;
      req <= req_n;
      mem <= mem_n;
      last_grant <= last_grant_n;
      cur <= cur_n;
      timer <= timer_n;
      overflow <= overflow_n;
      barin <= barin_n;
    end
  end
endmodule
